if_id_reg: RTL and testbench

IF/ID pipeline register placed directly downstream of the program counter stage. It captures the fetched PC, PC+4 and instruction each cycle and presents them to decode. Its hazard priority matches the PC stage: control_hazard over data_hazard over advance. A squash counter kills wrong-path slots when the branch resolves late.

---
 rtl/if_id_reg_if.sv | 24 ++
 rtl/if_id_reg.sv | 79 +++++++
 tb/tb_if_id_reg.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/if_id_reg_if.sv
// IF/ID bundle: fetch-side inputs, hazard controls and the registered decode-side view.
interface if_id_reg_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] pc_if;
  logic [DATA_W-1:0] inst_if;
  logic              data_hazard;
  logic              control_hazard;
  logic [DATA_W-1:0] pc_id;
  logic [DATA_W-1:0] pc4_id;
  logic [DATA_W-1:0] inst_id;
  logic              valid_id;
  logic              squash_busy;

  modport master (
    output pc_if, inst_if, data_hazard, control_hazard,
    input  pc_id, pc4_id, inst_id, valid_id, squash_busy
  );

  modport slave (
    input  pc_if, inst_if, data_hazard, control_hazard,
    output pc_id, pc4_id, inst_id, valid_id, squash_busy
  );
endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush/stall priority and a wrong-path squash counter.
// Optional performance counters are compiled in when IF_ID_PERF_EN is defined.
module if_id_reg #(
  parameter int                DATA_W       = 32,
  parameter logic [DATA_W-1:0] NOP_INST     = 32'h0000_0013,
  parameter int                SQUASH_DEPTH = 1
) (
  input  logic        clk,
  input  logic        rst,
  if_id_reg_if.slave  bus
`ifdef IF_ID_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt,
  output logic [31:0] perf_issue_cnt
`endif
);

  // SQUASH_DEPTH is legal in 1..3, so the reload value always fits in two bits.
  localparam logic [1:0] SQ_RELOAD = 2'(SQUASH_DEPTH - 1);

  logic [1:0] sq_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.pc_id    <= '0;
      bus.pc4_id   <= '0;
      bus.inst_id  <= NOP_INST;
      bus.valid_id <= 1'b0;
      sq_cnt       <= 2'd0;
    end else if (bus.control_hazard) begin
      bus.pc_id    <= '0;
      bus.pc4_id   <= '0;
      bus.inst_id  <= NOP_INST;
      bus.valid_id <= 1'b0;
      sq_cnt       <= SQ_RELOAD;
    end else if (!bus.data_hazard) begin
      if (sq_cnt != 2'd0) begin
        bus.pc_id    <= '0;
        bus.pc4_id   <= '0;
        bus.inst_id  <= NOP_INST;
        bus.valid_id <= 1'b0;
        sq_cnt       <= sq_cnt - 2'd1;
      end else begin
        bus.pc_id    <= bus.pc_if;
        bus.pc4_id   <= bus.pc_if + DATA_W'(4);
        bus.inst_id  <= bus.inst_if;
        bus.valid_id <= 1'b1;
      end
    end
  end

  assign bus.squash_busy = (sq_cnt != 2'd0);

`ifdef IF_ID_PERF_EN
  logic is_stall;
  logic is_issue;

  assign is_stall = bus.data_hazard && !bus.control_hazard;
  assign is_issue = !bus.control_hazard && !bus.data_hazard && (sq_cnt == 2'd0);

  // Counters stick at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_stall_cnt <= 32'd0;
      perf_flush_cnt <= 32'd0;
      perf_issue_cnt <= 32'd0;
    end else begin
      if (is_stall && (perf_stall_cnt != 32'hFFFF_FFFF))
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      if (bus.control_hazard && (perf_flush_cnt != 32'hFFFF_FFFF))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
      if (is_issue && (perf_issue_cnt != 32'hFFFF_FFFF))
        perf_issue_cnt <= perf_issue_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_id_reg.sv
// Drives two IF/ID registers (squash depth 1 and 2) with the same stimulus and
// compares both against a slot-level reference model.
module tb_if_id_reg;
  localparam int          DATA_W = 32;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  if_id_reg_if #(.DATA_W(DATA_W)) bus1 ();
  if_id_reg_if #(.DATA_W(DATA_W)) bus2 ();

`ifdef IF_ID_PERF_EN
  logic [31:0] ps1, pf1, pi1, ps2, pf2, pi2;
`endif

  if_id_reg #(.DATA_W(DATA_W), .NOP_INST(NOP), .SQUASH_DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
`ifdef IF_ID_PERF_EN
    , .perf_stall_cnt(ps1), .perf_flush_cnt(pf1), .perf_issue_cnt(pi1)
`endif
  );

  if_id_reg #(.DATA_W(DATA_W), .NOP_INST(NOP), .SQUASH_DEPTH(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
`ifdef IF_ID_PERF_EN
    , .perf_stall_cnt(ps2), .perf_flush_cnt(pf2), .perf_issue_cnt(pi2)
`endif
  );

  // Reference: what decode should see, plus how many upcoming fetch slots are still doomed.
  logic [31:0] m_pc   [2];
  logic [31:0] m_pc4  [2];
  logic [31:0] m_inst [2];
  logic        m_valid[2];
  int          m_kill [2];
  int          m_issue[2];
  int          m_stall;
  int          m_flush;

  int tests = 0;
  int fails = 0;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 2; k++) begin
      m_pc[k] = 0; m_pc4[k] = 0; m_inst[k] = NOP; m_valid[k] = 1'b0;
      m_kill[k] = 0; m_issue[k] = 0;
    end
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic modelStep(input logic [31:0] pc, input logic [31:0] inst,
                           input logic dh, input logic ch);
    for (int k = 0; k < 2; k++) begin
      if (ch) begin
        m_pc[k] = 0; m_pc4[k] = 0; m_inst[k] = NOP; m_valid[k] = 1'b0;
        m_kill[k] = k;
      end else if (!dh) begin
        if (m_kill[k] > 0) begin
          m_pc[k] = 0; m_pc4[k] = 0; m_inst[k] = NOP; m_valid[k] = 1'b0;
          m_kill[k] = m_kill[k] - 1;
        end else begin
          m_pc[k] = pc; m_pc4[k] = pc + 32'd4; m_inst[k] = inst; m_valid[k] = 1'b1;
          m_issue[k]++;
        end
      end
    end
    if (ch) m_flush++;
    else if (dh) m_stall++;
  endtask

  task automatic checkOutput(input string tag);
    checkVal({tag, " d1 pc_id"},       bus1.pc_id,             m_pc[0]);
    checkVal({tag, " d1 pc4_id"},      bus1.pc4_id,            m_pc4[0]);
    checkVal({tag, " d1 inst_id"},     bus1.inst_id,           m_inst[0]);
    checkVal({tag, " d1 valid_id"},    32'(bus1.valid_id),     32'(m_valid[0]));
    checkVal({tag, " d1 squash_busy"}, 32'(bus1.squash_busy),  32'(m_kill[0] > 0));
    checkVal({tag, " d2 pc_id"},       bus2.pc_id,             m_pc[1]);
    checkVal({tag, " d2 pc4_id"},      bus2.pc4_id,            m_pc4[1]);
    checkVal({tag, " d2 inst_id"},     bus2.inst_id,           m_inst[1]);
    checkVal({tag, " d2 valid_id"},    32'(bus2.valid_id),     32'(m_valid[1]));
    checkVal({tag, " d2 squash_busy"}, 32'(bus2.squash_busy),  32'(m_kill[1] > 0));
  endtask

  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                               input logic dh, input logic ch);
    bus1.pc_if = pc; bus1.inst_if = inst; bus1.data_hazard = dh; bus1.control_hazard = ch;
    bus2.pc_if = pc; bus2.inst_if = inst; bus2.data_hazard = dh; bus2.control_hazard = ch;
    @(posedge clk);
    #1;
    modelStep(pc, inst, dh, ch);
    checkOutput(tag);
  endtask

`ifdef IF_ID_PERF_EN
  task automatic checkPerf(input string tag);
    checkVal({tag, " d1 stall"}, ps1, 32'(m_stall));
    checkVal({tag, " d1 flush"}, pf1, 32'(m_flush));
    checkVal({tag, " d1 issue"}, pi1, 32'(m_issue[0]));
    checkVal({tag, " d2 stall"}, ps2, 32'(m_stall));
    checkVal({tag, " d2 flush"}, pf2, 32'(m_flush));
    checkVal({tag, " d2 issue"}, pi2, 32'(m_issue[1]));
  endtask
`endif

  initial begin
    logic [31:0] rpc, rinst;
    logic        rdh, rch;

    rst = 1'b1;
    bus1.pc_if = 0; bus1.inst_if = 0; bus1.data_hazard = 0; bus1.control_hazard = 0;
    bus2.pc_if = 0; bus2.inst_if = 0; bus2.data_hazard = 0; bus2.control_hazard = 0;
    modelClear();
    #12;
    checkOutput("reset");
    checkVal("reset nop", bus1.inst_id, 32'h0000_0013);
    #1 rst = 1'b0;

    applyStimulus("adv0", 32'h0, 32'h0050_0093, 1'b0, 1'b0);
    checkVal("adv0 pc4 const", bus1.pc4_id, 32'h4);
    applyStimulus("adv1", 32'h4, 32'h0010_0113, 1'b0, 1'b0);
    applyStimulus("adv2", 32'h8, 32'h0020_81b3, 1'b0, 1'b0);
    checkVal("adv2 pc4 const", bus2.pc4_id, 32'hC);

    for (int i = 0; i < 3; i++)
      applyStimulus("stall", 32'hC, 32'h0040_0213, 1'b1, 1'b0);
    checkVal("stall pc const", bus1.pc_id, 32'h8);
    applyStimulus("resume", 32'hC, 32'h0040_0213, 1'b0, 1'b0);

    applyStimulus("flush", 32'h10, 32'h0000_0463, 1'b0, 1'b1);
    checkVal("flush nop const", bus1.inst_id, 32'h0000_0013);
    applyStimulus("target", 32'h40, 32'h0050_0293, 1'b0, 1'b0);
    checkVal("target d1 pc const", bus1.pc_id, 32'h40);
    applyStimulus("target+4", 32'h44, 32'h0060_0313, 1'b0, 1'b0);

    applyStimulus("sq flush", 32'h20, 32'h0000_0063, 1'b0, 1'b1);
    applyStimulus("sq stall", 32'h80, 32'h0070_0393, 1'b1, 1'b0);
    applyStimulus("sq stall", 32'h80, 32'h0070_0393, 1'b1, 1'b0);
    checkVal("sq stall busy const", 32'(bus2.squash_busy), 32'd1);
    applyStimulus("sq bubble", 32'h80, 32'h0070_0393, 1'b0, 1'b0);
    applyStimulus("sq load", 32'h84, 32'h0080_0413, 1'b0, 1'b0);

    applyStimulus("both hz", 32'h90, 32'h0090_0493, 1'b1, 1'b1);
    applyStimulus("wrap a", 32'hFFFF_FFFC, 32'h00A0_0513, 1'b0, 1'b0);
    applyStimulus("wrap b", 32'hFFFF_FFFC, 32'h00A0_0513, 1'b0, 1'b0);
    checkVal("wrap pc4 const", bus2.pc4_id, 32'h0);

`ifdef IF_ID_PERF_EN
    checkPerf("perf pre-reset");
`endif

    applyStimulus("pre-rst flush", 32'h100, 32'h00B0_0593, 1'b0, 1'b1);
    #3 rst = 1'b1;
    #1;
    modelClear();
    checkOutput("async rst");
`ifdef IF_ID_PERF_EN
    checkPerf("perf async rst");
`endif
    #2 rst = 1'b0;
    applyStimulus("post rst", 32'h200, 32'h00C0_0613, 1'b0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      rpc   = $urandom() & 32'hFFFF_FFFC;
      rinst = $urandom();
      rdh   = ($urandom_range(0, 3) == 0);
      rch   = ($urandom_range(0, 5) == 0);
      applyStimulus("rand", rpc, rinst, rdh, rch);
    end
`ifdef IF_ID_PERF_EN
    checkPerf("perf final");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
